// File: rtl/key_accum_pkg.sv
// Shared types and constants for the key accumulator.
package key_accum_pkg;

  typedef enum logic [1:0] {
    REL,
    WAIT_PRS,
    PRS,
    WAIT_REL
  } deb_state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser and debouncer: 2-flop sync, four-state debounce FSM,
// one registered pulse per accepted press.
module key_debounce
  import key_accum_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             key_s;

  assign key_s       = sync_q[1];
  assign press_pulse = pulse_q;

  // Sync chain, arming and debounce FSM next-state.
  // armed_q only rises once the sync chain has refilled from the pin after
  // reset and shows the key released, so a key held across reset is ignored
  // until it has been let go.
  always_comb begin
    sync_d   = {sync_q[0], key_n};
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & key_s);
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    case (state_q)
      REL: begin
        if (armed_q && !key_s) begin
          state_d = WAIT_PRS;
          cnt_d   = '0;
        end
      end
      WAIT_PRS: begin
        if (key_s) begin
          state_d = REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS: begin
        if (key_s) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end
      end
      WAIT_REL: begin
        if (!key_s) begin
          state_d = PRS;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = REL;
    endcase
  end

  // State registers; key synchroniser resets to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '1;
      settle_q <= '0;
      armed_q  <= 1'b0;
      state_q  <= REL;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: rtl/key_accumulator.sv
// Push-button driven accumulator: debounced accumulate/clear keys add or
// subtract the synchronised switch word into the LED register.
// Optional macro KEY_ACCUM_SATURATE_EN: clamp on carry/borrow instead of wrap.
module key_accumulator
  import key_accum_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               accum_key_n,
  input  logic               clear_key_n,
  input  logic               mode_sub,
  input  logic [WIDTH-1:0]   sw,
  output logic [WIDTH-1:0]   led,
  output logic               overflow,
  output logic [COUNT_W-1:0] event_count,
  output logic               accum_pulse
);

  logic [WIDTH-1:0]   sw_m_q, sw_m_d, sw_s_q, sw_s_d;
  logic               mode_m_q, mode_m_d, mode_s_q, mode_s_d;
  logic [WIDTH-1:0]   led_q, led_d;
  logic               ovf_q, ovf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               accum_ev, clear_ev;
  logic [WIDTH:0]     sum;
  logic               flow;
  logic [WIDTH-1:0]   result;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_accum_deb (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (accum_key_n),
    .press_pulse(accum_ev)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_deb (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (clear_key_n),
    .press_pulse(clear_ev)
  );

  assign led         = led_q;
  assign overflow    = ovf_q;
  assign event_count = cnt_q;
  assign accum_pulse = accum_ev;

  // Operand synchronisers and accumulator update; clear beats accumulate.
  always_comb begin
    sw_m_d   = sw;
    sw_s_d   = sw_m_q;
    mode_m_d = mode_sub;
    mode_s_d = mode_m_q;

    if (mode_s_q == MODE_ADD) begin
      sum = {1'b0, led_q} + {1'b0, sw_s_q};
    end else begin
      sum = {1'b0, led_q} - {1'b0, sw_s_q};
    end
    flow = sum[WIDTH];

`ifdef KEY_ACCUM_SATURATE_EN
    if (flow) begin
      result = (mode_s_q == MODE_SUB) ? '0 : '1;
    end else begin
      result = sum[WIDTH-1:0];
    end
`else
    result = sum[WIDTH-1:0];
`endif

    led_d = led_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clear_ev) begin
      led_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (accum_ev) begin
      led_d = result;
      ovf_d = ovf_q | flow;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_m_q   <= '0;
      sw_s_q   <= '0;
      mode_m_q <= 1'b0;
      mode_s_q <= 1'b0;
      led_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sw_m_q   <= sw_m_d;
      sw_s_q   <= sw_s_d;
      mode_m_q <= mode_m_d;
      mode_s_q <= mode_s_d;
      led_q    <= led_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_key_accumulator.sv
// Directed self-checking bench for key_accumulator (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_key_accumulator;

  logic       clk;
  logic       reset_n;
  logic       accum_key_n;
  logic       clear_key_n;
  logic       mode_sub;
  logic [7:0] sw;
  logic [7:0] led;
  logic       overflow;
  logic [7:0] event_count;
  logic       accum_pulse;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  key_accumulator #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4),
    .COUNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .accum_key_n(accum_key_n),
    .clear_key_n(clear_key_n),
    .mode_sub   (mode_sub),
    .sw         (sw),
    .led        (led),
    .overflow   (overflow),
    .event_count(event_count),
    .accum_pulse(accum_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (accum_pulse) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press accumulate for 10 cycles, checking the exact pulse/update latency.
  task automatic accum_press(input string tag, input logic [7:0] exp_led);
    logic [7:0] prev;
    prev = led;
    accum_key_n = 1'b0;
    step(7);
    check({tag, "_pulse"}, 32'(accum_pulse), 32'd1);
    check({tag, "_hold"}, 32'(led), 32'(prev));
    step(1);
    check({tag, "_led"}, 32'(led), 32'(exp_led));
    check({tag, "_pulse_end"}, 32'(accum_pulse), 32'd0);
    step(2);
    accum_key_n = 1'b1;
    step(12);
  endtask

  task automatic clear_press();
    clear_key_n = 1'b0;
    step(10);
    clear_key_n = 1'b1;
    step(12);
  endtask

  initial begin
    int p0;
    reset_n     = 1'b1;
    accum_key_n = 1'b1;
    clear_key_n = 1'b1;
    mode_sub    = 1'b0;
    sw          = 8'h00;
    #1 reset_n = 1'b0;
    step(3);
    check("rst_led", 32'(led), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(event_count), 32'd0);
    check("rst_pulse", 32'(accum_pulse), 32'd0);
    reset_n = 1'b1;
    step(10);

    // Add 5 three times.
    sw = 8'h05;
    step(3);
    accum_press("add1", 8'h05);
    accum_press("add2", 8'h0A);
    accum_press("add3", 8'h0F);
    check("add_cnt", 32'(event_count), 32'd3);
    check("add_ovf", 32'(overflow), 32'd0);

    // Bounce: short lows never complete debounce; final hold gives one event.
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      accum_key_n = 1'b0;
      step(2);
      accum_key_n = 1'b1;
      step(2);
    end
    check("bounce_none", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_led_hold", 32'(led), 32'h0F);
    accum_key_n = 1'b0;
    step(12);
    accum_key_n = 1'b1;
    step(12);
    check("bounce_one", 32'(pulse_cnt - p0), 32'd1);
    check("bounce_led", 32'(led), 32'h14);
    check("bounce_cnt", 32'(event_count), 32'd4);

    // Overflow on add.
    clear_press();
    check("clr_led", 32'(led), 32'd0);
    check("clr_cnt", 32'(event_count), 32'd0);
    sw = 8'hFA;
    step(3);
    accum_press("ovf_pre", 8'hFA);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    sw = 8'h10;
    step(3);
`ifdef KEY_ACCUM_SATURATE_EN
    accum_press("ovf_add", 8'hFF);
`else
    accum_press("ovf_add", 8'h0A);
`endif
    check("ovf_set", 32'(overflow), 32'd1);
    sw = 8'h01;
    step(3);
`ifdef KEY_ACCUM_SATURATE_EN
    accum_press("ovf_sticky_add", 8'hFF);
`else
    accum_press("ovf_sticky_add", 8'h0B);
`endif
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(event_count), 32'd3);

    // Subtract with borrow.
    clear_press();
    check("clr2_ovf", 32'(overflow), 32'd0);
    sw = 8'h03;
    step(3);
    accum_press("sub_pre", 8'h03);
    mode_sub = 1'b1;
    sw = 8'h05;
    step(3);
`ifdef KEY_ACCUM_SATURATE_EN
    accum_press("sub", 8'h00);
`else
    accum_press("sub", 8'hFE);
`endif
    check("sub_ovf", 32'(overflow), 32'd1);

    // Make led non-zero before the priority test.
    mode_sub = 1'b0;
    sw = 8'h20;
    step(3);
`ifdef KEY_ACCUM_SATURATE_EN
    accum_press("pre_prio", 8'h20);
`else
    accum_press("pre_prio", 8'h1E);
`endif

    // Clear and accumulate accepted on the same edge: clear wins.
    accum_key_n = 1'b0;
    clear_key_n = 1'b0;
    step(10);
    accum_key_n = 1'b1;
    clear_key_n = 1'b1;
    step(12);
    check("prio_led", 32'(led), 32'd0);
    check("prio_ovf", 32'(overflow), 32'd0);
    check("prio_cnt", 32'(event_count), 32'd0);
    sw = 8'h01;
    step(3);
    accum_press("prio_after", 8'h01);
    check("prio_after_cnt", 32'(event_count), 32'd1);

    // Reset mid-debounce with the key held across reset release.
    sw = 8'h07;
    step(3);
    accum_key_n = 1'b0;
    step(4);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_led", 32'(led), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_cnt", 32'(event_count), 32'd0);
    check("mid_rst_pulse", 32'(accum_pulse), 32'd0);
    step(3);
    p0 = pulse_cnt;
    reset_n = 1'b1;
    step(20);
    check("held_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("held_cnt", 32'(event_count), 32'd0);
    check("held_led", 32'(led), 32'd0);
    accum_key_n = 1'b1;
    step(12);
    accum_press("repress", 8'h07);
    check("repress_cnt", 32'(event_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
